// File: rtl/rob_commit_pkg.sv
// Shared types and sizing for the ROB commit slice.
// Optional feature macro: ZERO_REG_EN (areg 0 hardwired to zero).
package rob_commit_pkg;

    localparam int unsigned ROB_ENTRIES = 16;
    localparam int unsigned NUM_PREGS   = 64;
    localparam int unsigned NUM_AREGS   = 32;

    localparam int unsigned ROB_IDX_W = $clog2(ROB_ENTRIES);
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
    localparam int unsigned AREG_W    = $clog2(NUM_AREGS);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } commit_state_t;

    typedef enum logic {
        CAUSE_EXC = 1'b0,
        CAUSE_IRQ = 1'b1
    } flush_cause_t;

    // Reset value of a CRAT entry: every areg maps onto the preg of the same number.
    function automatic logic [PREG_W-1:0] identity_preg(input logic [AREG_W-1:0] areg);
        return PREG_W'(areg);
    endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Commit-side bundle: ROB head, free-list return, interrupt, flush and CRAT recovery.
// The slave modport is the commit block, the master modport its environment.
interface rob_commit_if;
    import rob_commit_pkg::*;

    logic                 head_valid;
    logic                 head_busy;
    logic                 head_exception;
    logic                 head_macroop_begin;
    logic                 head_macroop_end;
    logic [AREG_W-1:0]    head_areg;
    logic [PREG_W-1:0]    head_preg;
    logic [ROB_IDX_W-1:0] head_idx;
    logic                 rob_pop;

    logic                 free_stall;
    logic                 free_valid;
    logic [PREG_W-1:0]    free_preg;

    logic                 irq_req;
    logic                 irq_ack;

    logic                 flush;
    logic [ROB_IDX_W-1:0] flush_idx;
    logic                 flush_cause;

    logic                 recover_valid;
    logic [AREG_W-1:0]    recover_areg;
    logic [PREG_W-1:0]    recover_preg;

    logic                 idle;

    modport master (
        output head_valid, head_busy, head_exception, head_macroop_begin,
               head_macroop_end, head_areg, head_preg, head_idx,
               free_stall, irq_req,
        input  rob_pop, free_valid, free_preg, irq_ack, flush, flush_idx,
               flush_cause, recover_valid, recover_areg, recover_preg, idle
    );

    modport slave (
        input  head_valid, head_busy, head_exception, head_macroop_begin,
               head_macroop_end, head_areg, head_preg, head_idx,
               free_stall, irq_req,
        output rob_pop, free_valid, free_preg, irq_ack, flush, flush_idx,
               flush_cause, recover_valid, recover_areg, recover_preg, idle
    );

endinterface

// File: rtl/rob_commit_crat_regfile.sv
// Committed register alias table: NUM_AREGS x PREG_W, two async read ports
// (commit-time free lookup, recovery stream), one sync write port, identity reset.
module crat_regfile
    import rob_commit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [AREG_W-1:0] commit_addr,
    output logic [PREG_W-1:0] commit_data,
    input  logic [AREG_W-1:0] recover_addr,
    output logic [PREG_W-1:0] recover_data,
    input  logic              wr_en,
    input  logic [AREG_W-1:0] wr_addr,
    input  logic [PREG_W-1:0] wr_data
);

    logic [PREG_W-1:0] mem [NUM_AREGS];

    // Identity mapping on reset, otherwise one committed mapping per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) begin
                mem[i] <= identity_preg(AREG_W'(i));
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents; a same-cycle write is not bypassed.
    always_comb begin
        commit_data  = mem[commit_addr];
        recover_data = mem[recover_addr];
    end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement of the ROB head with committed-RAT ownership,
// preg freeing, exception/interrupt flush and CRAT replay to rename.
// Optional feature macro: ZERO_REG_EN (areg 0 hardwired zero, never recovered).
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    rob_commit_if.slave  bus
);

    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_FLUSH   = FLUSH;
    localparam logic [1:0] S_RECOVER = RECOVER;

    localparam logic [AREG_W:0] LAST_AREG = (AREG_W+1)'(NUM_AREGS - 1);
`ifdef ZERO_REG_EN
    localparam logic [AREG_W:0] FIRST_AREG = (AREG_W+1)'(1);
`else
    localparam logic [AREG_W:0] FIRST_AREG = '0;
`endif

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 in_macroop;
    logic [AREG_W:0]      rec_cnt;
    logic [ROB_IDX_W-1:0] flush_idx_q;
    logic                 flush_cause_q;

    logic                 in_run;
    logic                 head_ready;
    logic                 exc;
    logic                 irq_take;
    logic                 commit;
    logic                 zero_dest;
    logic                 crat_we;
    logic [PREG_W-1:0]    crat_old;
    logic [PREG_W-1:0]    crat_rec;

    crat_regfile u_crat (
        .clk          (clk),
        .reset        (reset),
        .commit_addr  (bus.head_areg),
        .commit_data  (crat_old),
        .recover_addr (rec_cnt[AREG_W-1:0]),
        .recover_data (crat_rec),
        .wr_en        (crat_we),
        .wr_addr      (bus.head_areg),
        .wr_data      (bus.head_preg)
    );

    // Retirement decision: exception beats interrupt beats commit.
    always_comb begin
        in_run     = (state == S_RUN);
        head_ready = in_run & bus.head_valid & ~bus.head_busy;
        exc        = head_ready & bus.head_exception;
        irq_take   = in_run & bus.irq_req & ~in_macroop & ~exc;
        commit     = head_ready & ~bus.head_exception & ~bus.free_stall & ~irq_take;
`ifdef ZERO_REG_EN
        zero_dest  = (bus.head_areg == '0);
`else
        zero_dest  = 1'b0;
`endif
        crat_we    = commit & ~zero_dest;
    end

    // Commit-side outputs are combinational; flush/recover come from registered state.
    always_comb begin
        bus.rob_pop       = commit;
        bus.free_valid    = commit;
        bus.free_preg     = '0;
        if (commit) begin
            // A write to the zero register is discarded, so its preg goes straight back.
            bus.free_preg = zero_dest ? bus.head_preg : crat_old;
        end
        bus.irq_ack       = irq_take;
        bus.flush         = (state == S_FLUSH);
        bus.flush_idx     = flush_idx_q;
        bus.flush_cause   = flush_cause_q;
        bus.recover_valid = (state == S_RECOVER);
        bus.recover_areg  = bus.recover_valid ? rec_cnt[AREG_W-1:0] : '0;
        bus.recover_preg  = bus.recover_valid ? crat_rec : '0;
        bus.idle          = in_run;
    end

    // Next-state: FLUSH is a single beat, RECOVER ends on the last areg.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN:     if (exc | irq_take) state_nxt = S_FLUSH;
            S_FLUSH:   state_nxt = S_RECOVER;
            S_RECOVER: if (rec_cnt == LAST_AREG) state_nxt = S_RUN;
            default:   state_nxt = S_RUN;
        endcase
    end

    // State, macro-op tracking, recovery counter and latched flush info.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_RUN;
            in_macroop    <= 1'b0;
            rec_cnt       <= '0;
            flush_idx_q   <= '0;
            flush_cause_q <= CAUSE_EXC;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_RUN: begin
                    if (exc) begin
                        flush_idx_q   <= bus.head_idx;
                        flush_cause_q <= CAUSE_EXC;
                    end else if (irq_take) begin
                        flush_idx_q   <= bus.head_idx;
                        flush_cause_q <= CAUSE_IRQ;
                    end
                    if (commit) begin
                        in_macroop <= (bus.head_macroop_begin | in_macroop) & ~bus.head_macroop_end;
                    end
                end
                S_FLUSH: begin
                    in_macroop <= 1'b0;
                    rec_cnt    <= FIRST_AREG;
                end
                S_RECOVER: begin
                    rec_cnt <= rec_cnt + 1'b1;
                end
                default: begin
                    rec_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed table, hand-written flush /
// macro-op / reset sequences, then randomized traffic against a queue-based model.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    rob_commit_if bus ();

    rob_commit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 hv, hb, he, mb, me;
        logic [AREG_W-1:0]    areg;
        logic [PREG_W-1:0]    preg;
        logic [ROB_IDX_W-1:0] idx;
        logic                 stall, irq;
    } ins_t;

    typedef struct {
        logic                 rob_pop, free_valid;
        logic [PREG_W-1:0]    free_preg;
        logic                 irq_ack, flush;
        logic [ROB_IDX_W-1:0] flush_idx;
        logic                 flush_cause, recover_valid;
        logic [AREG_W-1:0]    recover_areg;
        logic [PREG_W-1:0]    recover_preg;
        logic                 idle;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

`ifdef ZERO_REG_EN
    localparam int FIRST_REC = 1;
    localparam bit ZERO_EN = 1'b1;
`else
    localparam int FIRST_REC = 0;
    localparam bit ZERO_EN = 1'b0;
`endif

    // Reference model: architectural mapping array plus a queue of scheduled
    // flush/recover beats; while the queue is non-empty the commit logic is frozen.
    int    crat [NUM_AREGS];
    bit    in_mac;
    int    last_idx;
    int    last_cause;
    outs_t pend [$];

    int checks = 0;
    int errors = 0;

    function automatic ins_t mk(bit hv, bit hb, bit he, bit mb, bit me, int areg, int preg,
                                int idx, bit stall, bit irq);
        ins_t r;
        r.hv = hv; r.hb = hb; r.he = he; r.mb = mb; r.me = me;
        r.areg = AREG_W'(areg); r.preg = PREG_W'(preg); r.idx = ROB_IDX_W'(idx);
        r.stall = stall; r.irq = irq;
        return r;
    endfunction

    function automatic outs_t quiet(int fidx, int fcause);
        outs_t r = '{default: '0};
        r.idle = 1'b1;
        r.flush_idx = ROB_IDX_W'(fidx);
        r.flush_cause = fcause[0];
        return r;
    endfunction

    function automatic outs_t retire(int fp);
        outs_t r = quiet(0, 0);
        r.rob_pop = 1'b1; r.free_valid = 1'b1; r.free_preg = PREG_W'(fp);
        return r;
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < NUM_AREGS; a++) crat[a] = a;
        in_mac = 1'b0;
        last_idx = 0;
        last_cause = 0;
        pend.delete();
    endfunction

    function automatic outs_t model_expect(ins_t i);
        outs_t e;
        bit exc, irq, com;
        if (pend.size() > 0) return pend[0];
        e = quiet(last_idx, last_cause);
        exc = i.hv && !i.hb && i.he;
        irq = i.irq && !in_mac && !exc;
        com = i.hv && !i.hb && !i.he && !i.stall && !irq;
        e.irq_ack = irq;
        e.rob_pop = com;
        e.free_valid = com;
        if (com) e.free_preg = (ZERO_EN && i.areg == 0) ? i.preg : PREG_W'(crat[i.areg]);
        return e;
    endfunction

    function automatic void model_edge(ins_t i, logic rst);
        bit exc, irq, com;
        outs_t r;
        if (!rst) begin
            model_reset();
            return;
        end
        if (pend.size() > 0) begin
            void'(pend.pop_front());
            return;
        end
        exc = i.hv && !i.hb && i.he;
        irq = i.irq && !in_mac && !exc;
        com = i.hv && !i.hb && !i.he && !i.stall && !irq;
        if (exc || irq) begin
            last_idx = int'(i.idx);
            last_cause = exc ? 0 : 1;
            in_mac = 1'b0;
            r = quiet(last_idx, last_cause);
            r.idle = 1'b0;
            r.flush = 1'b1;
            pend.push_back(r);
            for (int a = FIRST_REC; a < NUM_AREGS; a++) begin
                r = quiet(last_idx, last_cause);
                r.idle = 1'b0;
                r.recover_valid = 1'b1;
                r.recover_areg = AREG_W'(a);
                r.recover_preg = PREG_W'(crat[a]);
                pend.push_back(r);
            end
        end else if (com) begin
            if (!(ZERO_EN && i.areg == 0)) crat[i.areg] = int'(i.preg);
            in_mac = (i.mb || in_mac) && !i.me;
        end
    endfunction

    task automatic drive(ins_t i);
        bus.head_valid = i.hv;
        bus.head_busy = i.hb;
        bus.head_exception = i.he;
        bus.head_macroop_begin = i.mb;
        bus.head_macroop_end = i.me;
        bus.head_areg = i.areg;
        bus.head_preg = i.preg;
        bus.head_idx = i.idx;
        bus.free_stall = i.stall;
        bus.irq_req = i.irq;
    endtask

    task automatic check_outs(string name, outs_t e);
        outs_t a;
        bit bad;
        a.rob_pop = bus.rob_pop; a.free_valid = bus.free_valid; a.free_preg = bus.free_preg;
        a.irq_ack = bus.irq_ack; a.flush = bus.flush; a.flush_idx = bus.flush_idx;
        a.flush_cause = bus.flush_cause; a.recover_valid = bus.recover_valid;
        a.recover_areg = bus.recover_areg; a.recover_preg = bus.recover_preg; a.idle = bus.idle;
        bad = (a.rob_pop !== e.rob_pop) || (a.free_valid !== e.free_valid) ||
              (e.free_valid && a.free_preg !== e.free_preg) || (a.irq_ack !== e.irq_ack) ||
              (a.flush !== e.flush) || (a.flush_idx !== e.flush_idx) ||
              (a.flush_cause !== e.flush_cause) || (a.recover_valid !== e.recover_valid) ||
              (a.recover_areg !== e.recover_areg) || (a.recover_preg !== e.recover_preg) ||
              (a.idle !== e.idle);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s @%0t: got pop=%b fv=%b fp=%0d ack=%b fl=%b fi=%0d fc=%b rv=%b ra=%0d rp=%0d idle=%b, expected pop=%b fv=%b fp=%0d ack=%b fl=%b fi=%0d fc=%b rv=%b ra=%0d rp=%0d idle=%b",
                     name, $time, a.rob_pop, a.free_valid, a.free_preg, a.irq_ack, a.flush,
                     a.flush_idx, a.flush_cause, a.recover_valid, a.recover_areg, a.recover_preg,
                     a.idle, e.rob_pop, e.free_valid, e.free_preg, e.irq_ack, e.flush,
                     e.flush_idx, e.flush_cause, e.recover_valid, e.recover_areg, e.recover_preg,
                     e.idle);
        end
    endtask

    task automatic check_val(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic run_cycle(ins_t i, logic rst, string name, bit use_tbl, outs_t tbl_exp);
        drive(i);
        reset = rst;
        @(negedge clk);
        if (use_tbl) check_outs(name, tbl_exp);
        else         check_outs(name, model_expect(i));
        @(posedge clk);
        model_edge(i, rst);
        #1;
    endtask

    task automatic step(ins_t i, string name);
        run_cycle(i, 1'b1, name, 1'b0, quiet(0, 0));
    endtask

    task automatic drain(string name);
        int budget = 40;
        while (pend.size() > 0 && budget > 0) begin
            step(mk(0,0,0,0,0,0,0,0,0,0), name);
            budget--;
        end
        if (pend.size() > 0) begin
            errors++;
            $display("FAIL %s: recovery did not complete within cycle budget", name);
            pend.delete();
        end
    endtask

    ins_t  nop;
    vec_t  tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = mk(0,0,0,0,0,0,0,0,0,0);

        // Directed vectors from a freshly reset, identity-mapped CRAT.
        tbl[0]  = '{mk(0,0,0,0,0, 0, 0,0,0,0), quiet(0,0)};
        tbl[1]  = '{mk(1,0,0,0,0, 5,40,1,0,0), retire(5)};
        tbl[2]  = '{mk(1,0,0,0,0, 5,41,2,0,0), retire(40)};
        tbl[3]  = '{mk(1,0,0,0,0, 7,50,3,1,0), quiet(0,0)};
        tbl[4]  = '{mk(1,0,0,0,0, 7,50,3,1,0), quiet(0,0)};
        tbl[5]  = '{mk(1,0,0,0,0, 7,50,3,1,0), quiet(0,0)};
        tbl[6]  = '{mk(1,0,0,0,0, 7,50,3,0,0), retire(7)};
        tbl[7]  = '{mk(1,1,0,0,0, 9,60,4,0,0), quiet(0,0)};
        tbl[8]  = '{mk(1,0,0,0,0, 9,60,4,0,0), retire(9)};
        tbl[9]  = '{mk(1,0,0,0,0, 0,33,5,0,0), retire(ZERO_EN ? 33 : 0)};
        tbl[10] = '{mk(0,0,0,0,0, 0, 0,6,1,0), quiet(0,0)};

        drive(nop);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        run_cycle(nop, 1'b0, "reset_state", 1'b1, quiet(0,0));

        for (int n = 0; n < 11; n++) begin
            run_cycle(tbl[n].i, 1'b1, $sformatf("tbl%0d", n), 1'b1, tbl[n].o);
        end

        // Exception at ROB index 7, then full CRAT replay.
        step(mk(1,0,1,0,0,3,22,7,0,0), "exc_decide");
        check_val("exc_flush", int'(bus.flush), 1);
        check_val("exc_flush_idx", int'(bus.flush_idx), 7);
        check_val("exc_cause", int'(bus.flush_cause), 0);
        step(nop, "exc_flush_beat");
        check_val("rec_first_valid", int'(bus.recover_valid), 1);
        check_val("rec_first_areg", int'(bus.recover_areg), FIRST_REC);
        drain("exc_recover");
        check_val("exc_idle_after", int'(bus.idle), 1);

        // Interrupt held off until the macro-op's last uop retires.
        step(mk(1,0,0,1,0,3,20,8,0,0), "mac_begin");
        for (int k = 0; k < 3; k++) begin
            step(mk(0,0,0,0,0,0,0,9,0,1), "mac_irq_blocked");
            check_val("mac_no_ack", int'(bus.irq_ack), 0);
        end
        step(mk(1,0,0,0,1,4,21,9,0,1), "mac_end");
        check_val("mac_ack_after_end", int'(bus.irq_ack), 1);
        step(mk(0,0,0,0,0,0,0,10,0,1), "irq_take");
        check_val("irq_flush", int'(bus.flush), 1);
        check_val("irq_cause", int'(bus.flush_cause), 1);
        check_val("irq_flush_idx", int'(bus.flush_idx), 10);
        drain("irq_recover");

        // Exception wins over a simultaneous interrupt; reset then aborts recovery.
        step(mk(1,0,1,0,0,6,30,3,0,1), "exc_irq_same");
        check_val("exc_irq_cause", int'(bus.flush_cause), 0);
        step(nop, "abort_flush_beat");
        for (int b = 0; b < 10; b++) step(nop, "abort_recover");
        check_val("abort_at_beat10", int'(bus.recover_areg), FIRST_REC + 10);
        run_cycle(nop, 1'b0, "abort_reset", 1'b0, quiet(0,0));
        check_val("abort_rv", int'(bus.recover_valid), 0);
        check_val("abort_idle", int'(bus.idle), 1);
        step(mk(1,0,1,0,0,2,2,0,0,0), "forced_exc");
        step(nop, "forced_flush_beat");
        check_val("identity_first", int'(bus.recover_preg), FIRST_REC);
        drain("identity_recover");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            ins_t r;
            logic rst;
            r.hv = ($urandom_range(0, 9) < 8);
            r.hb = ($urandom_range(0, 9) < 2);
            r.he = ($urandom_range(0, 99) < 3);
            r.mb = ($urandom_range(0, 9) < 3);
            r.me = ($urandom_range(0, 9) < 3);
            r.areg = AREG_W'($urandom_range(0, NUM_AREGS - 1));
            r.preg = PREG_W'($urandom_range(0, NUM_PREGS - 1));
            r.idx = ROB_IDX_W'($urandom_range(0, ROB_ENTRIES - 1));
            r.stall = ($urandom_range(0, 9) < 2);
            r.irq = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 199) != 0);
            run_cycle(r, rst, "random", 1'b0, quiet(0,0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
Commit-side consumer of the reorder buffer. It retires the ROB head entry in order and owns the committed register alias table (CRAT, areg -> preg). On each retirement it frees the displaced physical register. On an exception or an interrupt taken at a macro-op boundary, it flushes the pipeline and streams the CRAT back to the rename stage. It sits between ROB storage, the physical-register free list and rename.

Parameters:
ROB_ENTRIES, 16, ROB depth; ROB_IDX_W = $clog2(ROB_ENTRIES)
NUM_PREGS, 64, physical registers; PREG_W = $clog2(NUM_PREGS)
NUM_AREGS, 32, architectural registers; AREG_W = $clog2(NUM_AREGS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
head_valid  in  1  ROB head entry valid
head_busy  in  1  head instruction still executing
head_exception  in  1  head entry caused an exception
head_macroop_begin  in  1  head is the first uop of a macro-instruction
head_macroop_end  in  1  head is the last uop of a macro-instruction
head_areg  in  AREG_W  destination areg of head
head_preg  in  PREG_W  destination preg of head
head_idx  in  ROB_IDX_W  ROB index of head
rob_pop  out  1  head retired this cycle; ROB advances head
free_stall  in  1  free list cannot accept a preg this cycle
free_valid  out  1  free_preg is returned to the free list
free_preg  out  PREG_W  preg being freed
irq_req  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse: interrupt taken
flush  out  1  one-cycle pulse: discard all speculative state
flush_idx  out  ROB_IDX_W  head_idx at flush decision
flush_cause  out  1  0 = exception, 1 = interrupt
recover_valid  out  1  recover_areg/recover_preg carry a CRAT entry
recover_areg  out  AREG_W  areg being restored
recover_preg  out  PREG_W  committed mapping of recover_areg
idle  out  1  FSM in RUN

Behaviour:
- Reset (reset==0 at posedge):
  - FSM -> RUN.
  - CRAT[i] = i for all i.
  - in_macroop = 0; recover counter = 0.
  - All pulse/valid outputs 0; flush_idx, flush_cause, recover_* = 0; idle = 1.
- Reset mid-FLUSH/RECOVER aborts the sequence; the next cycle is RUN with the identity CRAT.
- States: RUN, FLUSH, RECOVER.
- RUN, evaluated each cycle (combinational decision, state updates at the edge). Priority order:
  1. exc = head_valid & !head_busy & head_exception -> no pop, no free. Next state FLUSH; latch flush_idx = head_idx, cause = 0.
  2. irq_take = irq_req & !in_macroop & !exc -> irq_ack = 1 this cycle, no pop. Next state FLUSH; latch head_idx, cause = 1.
  3. commit = head_valid & !head_busy & !head_exception & !free_stall & !irq_take. Same cycle:
     - rob_pop = 1, free_valid = 1, free_preg = CRAT[head_areg] (old value).
     - At the edge: CRAT[head_areg] <= head_preg.
     - in_macroop <= (head_macroop_begin | in_macroop) & !head_macroop_end.
- free_valid is never asserted while free_stall = 1.
- At most one retirement per cycle. The CRAT read for the free uses the pre-edge value; no bypass is needed.
- FLUSH: exactly 1 cycle.
  - flush = 1 with latched flush_idx/cause.
  - in_macroop <= 0; counter <= 0; next state RECOVER.
- RECOVER: NUM_AREGS cycles.
  - recover_valid = 1, recover_areg = counter, recover_preg = CRAT[counter]; counter increments.
  - After areg NUM_AREGS-1, the next state is RUN.
  - The counter is AREG_W+1 bits wide so it does not wrap before the terminal compare.
- Outside RUN: rob_pop, free_valid and irq_ack are 0; head inputs and irq_req are ignored.
- flush/recover_* are registered (driven from state). rob_pop/free_*/irq_ack are combinational from the state and head inputs.
- An ROB empty condition (head_valid = 0) still allows an interrupt when !in_macroop.

Optional Feature:
ZERO_REG_EN.
- Defined: areg 0 is hardwired zero.
  - A commit with head_areg == 0 leaves CRAT[0] unchanged and frees head_preg itself.
  - RECOVER skips areg 0, so it lasts NUM_AREGS-1 cycles starting at areg 1.
- Undefined: areg 0 behaves as an ordinary register.

Decomposition:
- Shared package holds:
  - ROB_ENTRIES, NUM_PREGS and NUM_AREGS with derived widths;
  - commit_state_t enum {RUN, FLUSH, RECOVER};
  - flush_cause_t {CAUSE_EXC = 0, CAUSE_IRQ = 1}.
- One sub-module is natural: crat_regfile, which holds NUM_AREGS x PREG_W storage with two async read ports (commit, recover), one sync write port and identity reset.

Test Plan:
- Reset -> idle = 1, all pulses 0; 32-cycle forced recover reads CRAT[i] = i.
- Head {areg 5, preg 40, busy 0}, free_stall 0 -> rob_pop = 1, free_preg = 5. Next commit of areg 5, preg 41 -> free_preg = 40.
- Same head with free_stall = 1 for 3 cycles -> no pop or free for 3 cycles, then pop on the 4th cycle.
- Head exception at head_idx 7 -> next cycle flush = 1, flush_idx = 7, cause = 0. Then 32 recover beats, areg 0..31, with committed mappings. Then idle = 1.
- Commit begin-only uop, then assert irq_req -> no irq_ack until the end uop commits. Next cycle irq_ack = 1 and flush cause = 1.
- Exception at head and irq_req in the same cycle -> cause = 0, irq_ack = 0. Reset asserted during RECOVER beat 10 -> RUN, recover_valid = 0, identity CRAT.
